// File: rtl/uart_config_pkg.sv
// Shared UART framing constants and a helper that converts baud settings
// into clock counts, used by parents to size idle timeouts in character times.
package uart_config;

  localparam int UART_WIDTH = 8;
  localparam int UART_PADS  = 2;

  // Clocks for one full character (data bits plus start/stop), baud divisor rounded.
  function automatic int unsigned clks_per_char(input int unsigned clk_freq,
                                                input int unsigned baud_rate);
    return ((clk_freq + baud_rate / 2) / baud_rate) * (UART_WIDTH + UART_PADS);
  endfunction

endpackage

// File: rtl/uart_rx_framer_timer.sv
// Loadable idle down-counter: clear reloads, enable counts down, and expire
// flags an enabled cycle spent at zero. Also intended for the tx watchdog.
module rx_idle_timer #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic             expire
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Deliberately independent of clear so the parent may fold expiry into clear.
  assign expire = en && (cnt == '0);

endmodule

// File: rtl/uart_rx_framer.sv
// Packs UART bytes (first byte in the LSBs) into DATA_WIDTH-bit packets and
// discards a partial packet when the gap between its bytes grows too long.
module uart_rx_framer
  import uart_config::*;
#(
  parameter int DATA_WIDTH   = 24,
  parameter int TIMEOUT_CLKS = 100_000,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  flush,
  input  logic [7:0]            s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  timeout_drop,
  output logic [CNT_WIDTH-1:0]  drop_count,
  output logic                  partial
);

  localparam int BYTES = DATA_WIDTH / UART_WIDTH;
  localparam int IW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);

  localparam logic [0:0] ASSEMBLE = 1'b0;
  localparam logic [0:0] HOLD     = 1'b1;

  generate
    if (DATA_WIDTH % UART_WIDTH != 0 || DATA_WIDTH < UART_WIDTH) begin : g_bad_width
      $error("uart_rx_framer: DATA_WIDTH must be a non-zero multiple of 8");
    end
  endgenerate

  logic [0:0]    state, state_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic          hs;
  logic          expire;
  logic          drop;

  assign s_axis_tready = (state == ASSEMBLE) && !flush;
  assign hs            = s_axis_tvalid && s_axis_tready;
  // A byte arriving on the expiry cycle rescues the packet; flush also suppresses a drop.
  assign drop          = expire && !hs && !flush;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    if (state == HOLD) begin
      if (m_axis_tready) state_nxt = ASSEMBLE;
    end else if (flush || drop) begin
      idx_nxt = '0;
    end else if (hs) begin
      if (idx == LAST_IDX) begin
        idx_nxt   = '0;
        state_nxt = HOLD;
      end else begin
        idx_nxt = idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state         <= ASSEMBLE;
      idx           <= '0;
      m_axis_tvalid <= 1'b0;
      partial       <= 1'b0;
      timeout_drop  <= 1'b0;
      drop_count    <= '0;
    end else begin
      state         <= state_nxt;
      idx           <= idx_nxt;
      m_axis_tvalid <= (state_nxt == HOLD);
      partial       <= (state_nxt == ASSEMBLE) && (idx_nxt != '0);
      timeout_drop  <= drop;
      if (drop && drop_count != {CNT_WIDTH{1'b1}}) drop_count <= drop_count + 1'b1;
    end
  end

  // Bytes land in place; stale bytes after a drop are overwritten by the next packet.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      m_axis_tdata <= '0;
    end else begin
      for (int b = 0; b < BYTES; b++) begin
        if (hs && idx == IW'(b)) m_axis_tdata[UART_WIDTH*b +: UART_WIDTH] <= s_axis_tdata;
      end
    end
  end

  generate
    if (TIMEOUT_CLKS > 0) begin : g_timer
      localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
      logic timer_en;
      logic timer_clear;

      // Only a partially assembled packet is timed; HOLD backpressure never is.
      assign timer_en    = (state == ASSEMBLE) && (idx != '0);
      assign timer_clear = !timer_en || hs || flush || drop;

      rx_idle_timer #(.WIDTH(TW)) u_timer (
        .clk      (clk),
        .arstn    (arstn),
        .clear    (timer_clear),
        .en       (timer_en),
        .load_val (TW'(TIMEOUT_CLKS - 1)),
        .expire   (expire)
      );
    end else begin : g_no_timer
      assign expire = 1'b0;
    end
  endgenerate

endmodule
